// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences the MAR/MDR/RAM enables for one memory read or
// write. Each request is a single-cycle pulse from the control unit, which
// stalls on busy until this block pulses done.
module mem_access_ctrl #(
  parameter int RD_LAT = 2,  // cycles RAMread is held before MDR captures Mdatain
  parameter int WR_LAT = 1,  // cycles RAMwrite is held
  parameter int CW     = 4   // wait counter width
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rd_req,
  input  logic       wr_req,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRRead,
  output logic       RAMread,
  output logic       RAMwrite,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_RD_LATCH = 3'd3,
    S_WR_DATA  = 3'd4,
    S_WR_MEM   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Counter preloads: the wait state dwells for load+1 cycles, ending at 0.
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_op_wr;       // latched op: 0 = read, 1 = write
  logic          w_op_wr_next;

  // State, counter and latched op registers; clr aborts any transaction.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op_wr <= w_op_wr_next;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, read has priority.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_wr_next = r_op_wr;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          w_state_next = S_ADDR;
          w_op_wr_next = 1'b0;
        end else if (wr_req) begin
          w_state_next = S_ADDR;
          w_op_wr_next = 1'b1;
        end
      end
      S_ADDR: begin
        if (r_op_wr) begin
          w_state_next = S_WR_DATA;
        end else begin
          w_state_next = S_RD_WAIT;
          w_cnt_next   = RD_LOAD;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = S_RD_LATCH;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_RD_LATCH: w_state_next = S_DONE;
      S_WR_DATA: begin
        w_state_next = S_WR_MEM;
        w_cnt_next   = WR_LOAD;
      end
      S_WR_MEM: begin
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      // Unused code 7 falls back to IDLE on the next edge.
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore output decode of the state register.
  always_comb begin
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRRead  = 1'b0;
    RAMread  = 1'b0;
    RAMwrite = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_ADDR: begin
        MARin = 1'b1;
        busy  = 1'b1;
      end
      S_RD_WAIT: begin
        RAMread = 1'b1;
        busy    = 1'b1;
      end
      S_RD_LATCH: begin
        RAMread = 1'b1;
        MDRin   = 1'b1;
        MDRRead = 1'b1;
        busy    = 1'b1;
      end
      S_WR_DATA: begin
        MDRin = 1'b1;
        busy  = 1'b1;
      end
      S_WR_MEM: begin
        RAMwrite = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances with different latencies share
// the request inputs. Directed scenarios use instance 0 (RD_LAT=2, WR_LAT=3);
// the random soak checks all three against a cycle-offset timeline model.
module tb_mem_access_ctrl;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic rd_req = 1'b0;
  logic wr_req = 1'b0;

  logic [NI-1:0] marin, mdrin, mdrread, ramread, ramwrite, busy, done;
  logic [2:0]    st [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.RD_LAT(2), .WR_LAT(3), .CW(4)) u_dut0 (
    .clk(clk), .clr(clr), .rd_req(rd_req), .wr_req(wr_req),
    .MARin(marin[0]), .MDRin(mdrin[0]), .MDRRead(mdrread[0]),
    .RAMread(ramread[0]), .RAMwrite(ramwrite[0]), .busy(busy[0]),
    .done(done[0]), .state_out(st[0]));

  mem_access_ctrl #(.RD_LAT(1), .WR_LAT(15), .CW(4)) u_dut1 (
    .clk(clk), .clr(clr), .rd_req(rd_req), .wr_req(wr_req),
    .MARin(marin[1]), .MDRin(mdrin[1]), .MDRRead(mdrread[1]),
    .RAMread(ramread[1]), .RAMwrite(ramwrite[1]), .busy(busy[1]),
    .done(done[1]), .state_out(st[1]));

  mem_access_ctrl #(.RD_LAT(15), .WR_LAT(1), .CW(4)) u_dut2 (
    .clk(clk), .clr(clr), .rd_req(rd_req), .wr_req(wr_req),
    .MARin(marin[2]), .MDRin(mdrin[2]), .MDRRead(mdrread[2]),
    .RAMread(ramread[2]), .RAMwrite(ramwrite[2]), .busy(busy[2]),
    .done(done[2]), .state_out(st[2]));

  function automatic int rd_lat(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  function automatic int wr_lat(int i);
    return (i == 0) ? 3 : ((i == 1) ? 15 : 1);
  endfunction

  // Observed vector: {state, MARin, MDRin, MDRRead, RAMread, RAMwrite, busy, done}
  function automatic logic [9:0] obs(int i);
    return {st[i], marin[i], mdrin[i], mdrread[i], ramread[i], ramwrite[i], busy[i], done[i]};
  endfunction

  // Timeline model: expected vector k cycles after the accepting edge.
  function automatic logic [9:0] model_vec(bit act, bit op_wr, int k, int rl, int wl);
    logic [2:0] s;
    logic ma, mi, mr, rr, rw, d;
    s = 3'd0; ma = 0; mi = 0; mr = 0; rr = 0; rw = 0; d = 0;
    if (act && k >= 1) begin
      if (k == 1) begin
        s = 3'd1; ma = 1;
      end else if (!op_wr) begin
        if (k <= 1 + rl)      begin s = 3'd2; rr = 1; end
        else if (k == 2 + rl) begin s = 3'd3; rr = 1; mi = 1; mr = 1; end
        else if (k == 3 + rl) begin s = 3'd6; d = 1; end
      end else begin
        if (k == 2)           begin s = 3'd4; mi = 1; end
        else if (k <= 2 + wl) begin s = 3'd5; rw = 1; end
        else if (k == 3 + wl) begin s = 3'd6; d = 1; end
      end
    end
    return {s, ma, mi, mr, rr, rw, (s != 3'd0), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rd_req = 0; wr_req = 0; clr = 1;
    tick();
    clr = 0;
    tick();
  endtask

  // Hand-derived expected vectors for RD_LAT=2 read and WR_LAT=3 write.
  logic [9:0] rd_tab [1:6];
  logic [9:0] wr_tab [1:7];
  initial begin
    rd_tab[1] = 10'b001_1000010;
    rd_tab[2] = 10'b010_0001010;
    rd_tab[3] = 10'b010_0001010;
    rd_tab[4] = 10'b011_0111010;
    rd_tab[5] = 10'b110_0000011;
    rd_tab[6] = 10'b000_0000000;
    wr_tab[1] = 10'b001_1000010;
    wr_tab[2] = 10'b100_0100010;
    wr_tab[3] = 10'b101_0000110;
    wr_tab[4] = 10'b101_0000110;
    wr_tab[5] = 10'b101_0000110;
    wr_tab[6] = 10'b110_0000011;
    wr_tab[7] = 10'b000_0000000;
  end

  task automatic test_reset();
    clr = 1; rd_req = 1;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (obs(i) !== 10'd0) begin
        bad++;
        $display("FAIL reset inst%0d: got %b want %b", i, obs(i), 10'd0);
      end
    end
    clr = 0;
    tick();
    rd_req = 0;
    total++;
    if (obs(0) !== 10'b001_1000010) begin
      bad++;
      $display("FAIL reset_accept: got %b want %b", obs(0), 10'b001_1000010);
    end
    repeat (20) tick();
  endtask

  task automatic test_read();
    do_reset();
    rd_req = 1;
    tick();
    rd_req = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      total++;
      if (obs(0) !== rd_tab[c]) begin
        bad++;
        $display("FAIL read c%0d: got %b want %b", c, obs(0), rd_tab[c]);
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    wr_req = 1;
    tick();
    wr_req = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      total++;
      if (obs(0) !== wr_tab[c]) begin
        bad++;
        $display("FAIL write c%0d: got %b want %b", c, obs(0), wr_tab[c]);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rd_req = 1; wr_req = 1;
    tick();
    rd_req = 0;  // wr_req stays high through the read
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      total++;
      if (obs(0) !== rd_tab[c]) begin
        bad++;
        $display("FAIL simul_read c%0d: got %b want %b", c, obs(0), rd_tab[c]);
      end
    end
    tick();
    total++;
    if (obs(0) !== wr_tab[1]) begin
      bad++;
      $display("FAIL simul_wr_start: got %b want %b", obs(0), wr_tab[1]);
    end
    wr_req = 0;
    tick();
    total++;
    if (obs(0) !== wr_tab[2]) begin
      bad++;
      $display("FAIL simul_wr_data: got %b want %b", obs(0), wr_tab[2]);
    end
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_req = 1;
    tick();
    for (int c = 2; c <= 6; c++) tick();
    total++;
    if (obs(0) !== rd_tab[6]) begin
      bad++;
      $display("FAIL b2b_idle: got %b want %b", obs(0), rd_tab[6]);
    end
    tick();
    rd_req = 0;
    total++;
    if (obs(0) !== rd_tab[1]) begin
      bad++;
      $display("FAIL b2b_restart: got %b want %b", obs(0), rd_tab[1]);
    end
    repeat (10) tick();
  endtask

  task automatic test_abort();
    do_reset();
    rd_req = 1;
    tick();
    rd_req = 0;
    tick();
    tick();
    clr = 1;  // in cycle 3, RD_WAIT
    tick();
    clr = 0;
    total++;
    if (obs(0) !== 10'd0) begin
      bad++;
      $display("FAIL abort: got %b want %b", obs(0), 10'd0);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (obs(0) !== 10'd0) begin
        bad++;
        $display("FAIL abort_quiet c%0d: got %b want %b", c, obs(0), 10'd0);
      end
    end
  endtask

  task automatic test_soak();
    bit act [NI];
    bit opw [NI];
    int s   [NI];
    int acc [NI];
    int dn  [NI];
    int r, rl, wl, lat;
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < NI; i++) begin
      act[i] = 0; opw[i] = 0; s[i] = 0; acc[i] = 0; dn[i] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      if (n < 2940) begin
        r = $urandom_range(0, 9);
        rd_req = (r < 2) || (r == 4);
        wr_req = (r >= 2) && (r <= 4);
      end else begin
        rd_req = 0; wr_req = 0;
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        rl  = rd_lat(i);
        wl  = wr_lat(i);
        lat = (opw[i]) ? wl : rl;
        // DUT was in IDLE during the cycle just ended?
        if (!act[i] || (cyc - 1 - s[i]) >= 4 + lat) begin
          act[i] = 0;
          if (rd_req || wr_req) begin
            act[i] = 1;
            s[i]   = cyc - 1;
            opw[i] = !rd_req;
            acc[i]++;
          end
        end
        e = model_vec(act[i], opw[i], cyc - s[i], rl, wl);
        total++;
        if (obs(i) !== e) begin
          bad++;
          $display("FAIL soak inst%0d cyc%0d: got %b want %b", i, cyc, obs(i), e);
        end
        total++;
        if ((ramread[i] && ramwrite[i]) || (marin[i] && mdrin[i])) begin
          bad++;
          $display("FAIL soak_excl inst%0d cyc%0d: got rr=%b rw=%b ma=%b mi=%b want no overlap",
                   i, cyc, ramread[i], ramwrite[i], marin[i], mdrin[i]);
        end
        if (done[i] === 1'b1) dn[i]++;
      end
    end
    for (int i = 0; i < NI; i++) begin
      total++;
      if (dn[i] !== acc[i]) begin
        bad++;
        $display("FAIL soak_done_count inst%0d: got %0d want %0d", i, dn[i], acc[i]);
      end
      $display("soak inst%0d: accepted=%0d done=%0d", i, acc[i], dn[i]);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_back_to_back();
    test_abort();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
